// File: rtl/demux4_pkg.sv
// ============================================================================
// Module   : demux4_pkg
// Brief    : Shared constants and types for the four-way stream demultiplexer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux4_pkg;

    localparam int NUM_CH     = 4;
    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 2;

    typedef logic [1:0]                  chan_t;
    typedef logic [$clog2(DEPTH_DEF):0]  fifo_cnt_t;

endpackage

`default_nettype wire

// File: rtl/demux4_chan_fifo.sv
// ============================================================================
// Module   : demux4_chan_fifo
// Brief    : Single-channel synchronous FIFO with valid/ready read side.
//            Optional delivered-word counter under DEMUX4_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux4_chan_fifo
    import demux4_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    output logic              o_full,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
`ifdef DEMUX4_CNT_EN
    ,
    output logic [15:0]       o_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == C_FULL_CNT);
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];

    // Pop only when a word is present, so ready on an empty channel is inert.
    assign w_push = i_push && !o_full;
    assign w_pop  = o_valid && i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef DEMUX4_CNT_EN
    logic [15:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_cnt = r_cnt;
`endif

endmodule

`default_nettype wire

// File: rtl/demux4_stream.sv
// ============================================================================
// Module   : demux4_stream
// Brief    : Four-way registered demultiplexer steering a tagged input stream
//            into per-channel FIFOs. Optional counters: DEMUX4_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux4_stream
    import demux4_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  chan_t             i_ctrl,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data_0,
    output logic [DATA_W-1:0] o_data_1,
    output logic [DATA_W-1:0] o_data_2,
    output logic [DATA_W-1:0] o_data_3,
    output logic              o_valid_0,
    output logic              o_valid_1,
    output logic              o_valid_2,
    output logic              o_valid_3,
    input  logic              i_ready_0,
    input  logic              i_ready_1,
    input  logic              i_ready_2,
    input  logic              i_ready_3
`ifdef DEMUX4_CNT_EN
    ,
    output logic [15:0]       o_cnt_0,
    output logic [15:0]       o_cnt_1,
    output logic [15:0]       o_cnt_2,
    output logic [15:0]       o_cnt_3
`endif
);

    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_valid;
    logic [NUM_CH-1:0] w_ready;
    logic [DATA_W-1:0] w_data [NUM_CH];
`ifdef DEMUX4_CNT_EN
    logic [15:0]       w_cnt  [NUM_CH];
`endif

    // o_ready depends only on i_ctrl and registered fill state.
    assign o_ready = !w_full[i_ctrl];
    assign w_ready = {i_ready_3, i_ready_2, i_ready_1, i_ready_0};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_push[k] = i_valid && o_ready && (i_ctrl == chan_t'(k));

        demux4_chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_push      (w_push[k]),
            .i_push_data (i_data),
            .o_full      (w_full[k]),
            .o_valid     (w_valid[k]),
            .i_ready     (w_ready[k]),
            .o_data      (w_data[k])
`ifdef DEMUX4_CNT_EN
            ,
            .o_cnt       (w_cnt[k])
`endif
        );
    end

    assign o_valid_0 = w_valid[0];
    assign o_valid_1 = w_valid[1];
    assign o_valid_2 = w_valid[2];
    assign o_valid_3 = w_valid[3];
    assign o_data_0  = w_data[0];
    assign o_data_1  = w_data[1];
    assign o_data_2  = w_data[2];
    assign o_data_3  = w_data[3];
`ifdef DEMUX4_CNT_EN
    assign o_cnt_0   = w_cnt[0];
    assign o_cnt_1   = w_cnt[1];
    assign o_cnt_2   = w_cnt[2];
    assign o_cnt_3   = w_cnt[3];
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux4_stream.sv
// ============================================================================
// Module   : tb_demux4_stream
// Brief    : Directed self-checking bench for demux4_stream (DEMUX4_CNT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux4_stream;

    logic        clk;
    logic        rst_n;
    logic [15:0] data;
    logic [1:0]  ctrl;
    logic        valid;
    logic        ready;
    logic [15:0] d0, d1, d2, d3;
    logic        v0, v1, v2, v3;
    logic        r0, r1, r2, r3;
`ifdef DEMUX4_CNT_EN
    logic [15:0] c0, c1, c2, c3;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    demux4_stream dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_data    (data),
        .i_ctrl    (ctrl),
        .i_valid   (valid),
        .o_ready   (ready),
        .o_data_0  (d0),
        .o_data_1  (d1),
        .o_data_2  (d2),
        .o_data_3  (d3),
        .o_valid_0 (v0),
        .o_valid_1 (v1),
        .o_valid_2 (v2),
        .o_valid_3 (v3),
        .i_ready_0 (r0),
        .i_ready_1 (r1),
        .i_ready_2 (r2),
        .i_ready_3 (r3)
`ifdef DEMUX4_CNT_EN
        ,
        .o_cnt_0   (c0),
        .o_cnt_1   (c1),
        .o_cnt_2   (c2),
        .o_cnt_3   (c3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        data  = '0;
        ctrl  = '0;
        valid = 1'b0;
        {r3, r2, r1, r0} = 4'hF;

        // Reset state
        #3;
        chk("rst_valid", {28'd0, v3, v2, v1, v0}, 32'h0);
        chk("rst_data01", {d1, d0}, 32'h0);
        chk("rst_data23", {d3, d2}, 32'h0);
        for (int c = 0; c < 4; c++) begin
            ctrl = 2'(c);
            #1;
            chk($sformatf("rst_ready_c%0d", c), {31'd0, ready}, 32'h1);
        end
        tick();
        rst_n = 1'b1;
        tick();

        // Route one word per channel on consecutive cycles
        valid = 1'b1; ctrl = 2'd0; data = 16'h000a;
        tick();
        chk("route_v0", {28'd0, v3, v2, v1, v0}, 32'h1);
        chk("route_d0", {16'd0, d0}, 32'h000a);
        ctrl = 2'd1; data = 16'h000b;
        tick();
        chk("route_v1", {28'd0, v3, v2, v1, v0}, 32'h2);
        chk("route_d1", {16'd0, d1}, 32'h000b);
        ctrl = 2'd2; data = 16'h000c;
        tick();
        chk("route_v2", {28'd0, v3, v2, v1, v0}, 32'h4);
        chk("route_d2", {16'd0, d2}, 32'h000c);
        ctrl = 2'd3; data = 16'h000d;
        tick();
        chk("route_v3", {28'd0, v3, v2, v1, v0}, 32'h8);
        chk("route_d3", {16'd0, d3}, 32'h000d);
        valid = 1'b0;
        tick();
        chk("route_idle", {28'd0, v3, v2, v1, v0}, 32'h0);

        // Back-pressure on channel 2
        r2 = 1'b0;
        valid = 1'b1; ctrl = 2'd2; data = 16'h1111;
        #1;
        chk("bp_ready_empty", {31'd0, ready}, 32'h1);
        tick();
        data = 16'h2222;
        #1;
        chk("bp_ready_one", {31'd0, ready}, 32'h1);
        tick();
        data = 16'h3333;
        #1;
        chk("bp_ready_full", {31'd0, ready}, 32'h0);
        chk("bp_head", {15'd0, v2, d2}, {15'd0, 1'b1, 16'h1111});
        tick();
        chk("bp_hold_ready", {31'd0, ready}, 32'h0);
        chk("bp_hold_head", {16'd0, d2}, 32'h1111);

        // Isolation: channel 0 still flows while channel 2 is full
        ctrl = 2'd0; data = 16'h0aaa;
        #1;
        chk("iso_ready_c0", {31'd0, ready}, 32'h1);
        tick();
        chk("iso_d0", {15'd0, v0, d0}, {15'd0, 1'b1, 16'h0aaa});
        ctrl = 2'd2; data = 16'h3333;
        #1;
        chk("iso_ready_c2", {31'd0, ready}, 32'h0);
        tick();
        chk("iso_v0_done", {31'd0, v0}, 32'h0);

        // Drain channel 2; the held 0x3333 enters after the first pop
        r2 = 1'b1;
        tick();
        chk("drain_1", {15'd0, v2, d2}, {15'd0, 1'b1, 16'h2222});
        chk("drain_ready_rise", {31'd0, ready}, 32'h1);
        tick();
        valid = 1'b0;
        chk("drain_2", {15'd0, v2, d2}, {15'd0, 1'b1, 16'h3333});
        tick();
        chk("drain_empty", {31'd0, v2}, 32'h0);

        // Simultaneous push and pop on channel 1
        r1 = 1'b0;
        valid = 1'b1; ctrl = 2'd1; data = 16'h0011;
        tick();
        chk("pp_pre", {15'd0, v1, d1}, {15'd0, 1'b1, 16'h0011});
        r1 = 1'b1; data = 16'h00ff;
        tick();
        valid = 1'b0;
        chk("pp_head", {15'd0, v1, d1}, {15'd0, 1'b1, 16'h00ff});
        tick();
        chk("pp_empty", {31'd0, v1}, 32'h0);

        // Asynchronous reset with channels 0 and 3 occupied, channel 3 full
        r0 = 1'b0; r3 = 1'b0;
        valid = 1'b1; ctrl = 2'd0; data = 16'h0123;
        tick();
        ctrl = 2'd3; data = 16'h0321;
        tick();
        data = 16'h0322;
        tick();
        valid = 1'b0;
        #1;
        chk("ar_pre_valid", {28'd0, v3, v2, v1, v0}, 32'h9);
        chk("ar_pre_ready", {31'd0, ready}, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {28'd0, v3, v2, v1, v0}, 32'h0);
        chk("ar_data03", {d3, d0}, 32'h0);
        chk("ar_ready", {31'd0, ready}, 32'h1);
        tick();
        rst_n = 1'b1;
        {r3, r2, r1, r0} = 4'hF;
        tick();

`ifdef DEMUX4_CNT_EN
        // Delivered-word counters
        valid = 1'b1; ctrl = 2'd3;
        for (int w = 0; w < 3; w++) begin
            data = 16'h0100 + 16'(w);
            tick();
        end
        valid = 1'b0;
        tick();
        chk("cnt3_three", {16'd0, c3}, 32'h3);
        chk("cnt_others", {c2 | c1 | c0, 16'd0}, 32'h0);
        force dut.g_ch[3].u_fifo.r_cnt = 16'hFFFF;
        #1;
        release dut.g_ch[3].u_fifo.r_cnt;
        valid = 1'b1; data = 16'h0200;
        tick();
        valid = 1'b0;
        tick();
        chk("cnt3_wrap", {16'd0, c3}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
